// File: rtl/grid_mover_if.sv
// grid_mover_if: tile permission handshake between the sprite mover (master) and the map (slave).
interface grid_mover_if;
  logic       tile_req;
  logic [9:0] tile_req_x;
  logic [9:0] tile_req_y;
  logic       tile_ack;
  logic       tile_blocked;
  modport master (output tile_req, tile_req_x, tile_req_y, input tile_ack, tile_blocked);
  modport slave (input tile_req, tile_req_x, tile_req_y, output tile_ack, tile_blocked);
endinterface

// File: rtl/grid_mover.sv
// grid_mover: tile-aligned WASD sprite mover that asks the map before entering each tile.
// Defining GRID_MOVER_REVERSE_EN lets an opposite key turn the sprite back mid-tile.
module grid_mover #(
  parameter int         TILE      = 16,
  parameter int         STEP      = 2,
  parameter int         X_MIN     = 0,
  parameter int         X_MAX     = 624,
  parameter int         Y_MIN     = 0,
  parameter int         Y_MAX     = 464,
  parameter int         START_X   = 32,
  parameter int         START_Y   = 32,
  parameter int         KEY_BYTES = 2,
  parameter logic [7:0] KEY_UP    = 8'h1a,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_DOWN  = 8'h16,
  parameter logic [7:0] KEY_RIGHT = 8'h07
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [8*KEY_BYTES-1:0] keycode,
  grid_mover_if.master           map,
  output logic [9:0]             PosX,
  output logic [9:0]             PosY,
  output logic [1:0]             Dir,
  output logic                   Moving
);
  localparam int          LOG    = $clog2(TILE);
  localparam logic [6:0]  N      = 7'(TILE / STEP);
  localparam logic [9:0]  S      = 10'(STEP);
  localparam logic [9:0]  T      = 10'(TILE);
  localparam logic [10:0] X_LO   = 11'(X_MIN);
  localparam logic [10:0] X_SPAN = 11'(X_MAX - X_MIN);
  localparam logic [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic [10:0] Y_SPAN = 11'(Y_MAX - Y_MIN);
  typedef enum logic [1:0] {IDLE, QUERY, MOVE} state_t;
  state_t      state, state_n;
  logic [9:0]  pos_x, pos_y, dst_x, dst_y;
  logic [9:0]  pos_x_n, pos_y_n, dst_x_n, dst_y_n;
  logic [9:0]  dmx, dmy, base_x, base_y, stp_x, stp_y;
  logic [10:0] tgt_x, tgt_y;
  logic [1:0]  dir, dir_n, key_dir, mdir;
  logic [6:0]  cnt, cnt_n, eff;
  logic        key_vld, tgt_ok, rev, launch;
  always_comb begin
    key_vld = 1'b0;
    key_dir = 2'd0;
    for (int i = KEY_BYTES - 1; i >= 0; i--) begin
      if (keycode[8*i +: 8] == KEY_UP) begin key_vld = 1'b1; key_dir = 2'd0; end
      else if (keycode[8*i +: 8] == KEY_LEFT) begin key_vld = 1'b1; key_dir = 2'd1; end
      else if (keycode[8*i +: 8] == KEY_DOWN) begin key_vld = 1'b1; key_dir = 2'd2; end
      else if (keycode[8*i +: 8] == KEY_RIGHT) begin key_vld = 1'b1; key_dir = 2'd3; end
    end
  end
`ifdef GRID_MOVER_REVERSE_EN
  assign rev = state == MOVE && key_vld && key_dir == (dir ^ 2'd2) && cnt != N;
`else
  assign rev = 1'b0;
`endif
  // On reversal the destination becomes the origin tile and the step count mirrors
  assign mdir   = rev ? dir ^ 2'd2 : dir;
  assign eff    = rev ? N - cnt : cnt;
  assign dmx    = !rev ? dst_x : mdir == 2'd1 ? dst_x - T : mdir == 2'd3 ? dst_x + T : dst_x;
  assign dmy    = !rev ? dst_y : mdir == 2'd0 ? dst_y - T : mdir == 2'd2 ? dst_y + T : dst_y;
  assign base_x = state == MOVE ? dmx : pos_x;
  assign base_y = state == MOVE ? dmy : pos_y;
  // 11-bit target: a step below 0 wraps far above the span and fails the range test
  assign tgt_x  = {1'b0, base_x} + (key_dir == 2'd3 ? {1'b0, T} : 11'd0) - (key_dir == 2'd1 ? {1'b0, T} : 11'd0);
  assign tgt_y  = {1'b0, base_y} + (key_dir == 2'd2 ? {1'b0, T} : 11'd0) - (key_dir == 2'd0 ? {1'b0, T} : 11'd0);
  assign tgt_ok = (tgt_x - X_LO) <= X_SPAN && (tgt_y - Y_LO) <= Y_SPAN;
  assign stp_x  = mdir == 2'd3 ? pos_x + S : mdir == 2'd1 ? pos_x - S : pos_x;
  assign stp_y  = mdir == 2'd2 ? pos_y + S : mdir == 2'd0 ? pos_y - S : pos_y;
  assign launch = key_vld && (state == IDLE || (state == MOVE && eff == 7'd1));
  always_comb begin
    state_n = state;
    pos_x_n = pos_x;
    pos_y_n = pos_y;
    dst_x_n = dst_x;
    dst_y_n = dst_y;
    dir_n   = dir;
    cnt_n   = cnt;
    case (state)
      IDLE: state_n = IDLE;
      QUERY: if (map.tile_ack) begin
        state_n = map.tile_blocked ? IDLE : MOVE;
        cnt_n   = N;
      end
      MOVE: begin
        pos_x_n = stp_x;
        pos_y_n = stp_y;
        dst_x_n = dmx;
        dst_y_n = dmy;
        dir_n   = mdir;
        cnt_n   = eff - 7'd1;
        state_n = eff == 7'd1 ? IDLE : MOVE;
      end
      default: state_n = IDLE;
    endcase
    if (launch) begin
      dir_n = key_dir;
      if (tgt_ok) begin
        state_n = QUERY;
        dst_x_n = tgt_x[9:0];
        dst_y_n = tgt_y[9:0];
      end
    end
  end
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= IDLE;
      pos_x <= 10'(START_X);
      pos_y <= 10'(START_Y);
      dst_x <= 10'(START_X);
      dst_y <= 10'(START_Y);
      dir   <= 2'd2;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pos_x <= pos_x_n;
      pos_y <= pos_y_n;
      dst_x <= dst_x_n;
      dst_y <= dst_y_n;
      dir   <= dir_n;
      cnt   <= cnt_n;
    end
  end
  assign map.tile_req   = state == QUERY;
  assign map.tile_req_x = dst_x >> LOG;
  assign map.tile_req_y = dst_y >> LOG;
  assign PosX   = pos_x;
  assign PosY   = pos_y;
  assign Dir    = dir;
  assign Moving = state == MOVE;
endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: scenario tasks with a position/direction scoreboard for grid_mover.
module tb_grid_mover;
  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [15:0] keycode;
  logic [9:0]  PosX, PosY;
  logic [1:0]  Dir;
  logic        Moving;
  int          tests = 0;
  int          fails = 0;
  typedef struct packed {logic [9:0] x; logic [9:0] y; logic [1:0] d; logic m;} exp_t;
  exp_t sb[$];
  grid_mover_if map ();
  grid_mover dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .keycode(keycode),
    .map(map),
    .PosX(PosX),
    .PosY(PosY),
    .Dir(Dir),
    .Moving(Moving)
  );
  always #5 frame_clk = ~frame_clk;
  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask
  task automatic push(input int x, input int y, input int d, input bit m);
    sb.push_back('{x: 10'(x), y: 10'(y), d: 2'(d), m: m});
  endtask
  task automatic do_reset;
    Reset = 1'b1;
    keycode = '0;
    map.tile_ack = 1'b0;
    map.tile_blocked = 1'b0;
    tick;
    Reset = 1'b0;
  endtask
  task automatic go(input logic [15:0] k);
    keycode = k;
    tick;
    map.tile_ack = 1'b1;
    tick;
    map.tile_ack = 1'b0;
    keycode = '0;
    repeat (8) tick;
  endtask
  task automatic test_reset;
    do_reset;
    tests++;
    if (PosX !== 10'd32 || PosY !== 10'd32) begin
      fails++;
      $display("FAIL reset_pos: got (%0d,%0d) expected (32,32)", PosX, PosY);
    end
    tests++;
    if (Dir !== 2'd2) begin fails++; $display("FAIL reset_dir: got %0d expected 2", Dir); end
    tests++;
    if (Moving !== 1'b0) begin fails++; $display("FAIL reset_moving: got %0b expected 0", Moving); end
    tests++;
    if (map.tile_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b expected 0", map.tile_req); end
    tests++;
    if (map.tile_req_x !== 10'd2 || map.tile_req_y !== 10'd2) begin
      fails++;
      $display("FAIL reset_req_xy: got (%0d,%0d) expected (2,2)", map.tile_req_x, map.tile_req_y);
    end
  endtask
  task automatic test_move_right;
    exp_t e;
    do_reset;
    keycode = 16'h0007;
    tick;
    tests++;
    if (map.tile_req !== 1'b1 || map.tile_req_x !== 10'd3 || map.tile_req_y !== 10'd2 || Dir !== 2'd3) begin
      fails++;
      $display("FAIL right_req: got req=%0b (%0d,%0d) dir=%0d expected req=1 (3,2) dir=3",
               map.tile_req, map.tile_req_x, map.tile_req_y, Dir);
    end
    map.tile_ack = 1'b1;
    push(32, 32, 3, 1'b1);
    for (int i = 1; i <= 8; i++) push(32 + 2 * i, 32, 3, i != 8);
    for (int i = 0; i < 9; i++) begin
      tick;
      if (i == 0) begin map.tile_ack = 1'b0; keycode = '0; end
      e = sb.pop_front();
      tests++;
      if (PosX !== e.x || PosY !== e.y || Dir !== e.d || Moving !== e.m) begin
        fails++;
        $display("FAIL right_step%0d: got x=%0d y=%0d dir=%0d mv=%0b expected x=%0d y=%0d dir=%0d mv=%0b",
                 i, PosX, PosY, Dir, Moving, e.x, e.y, e.d, e.m);
      end
    end
    tests++;
    if (map.tile_req !== 1'b0) begin fails++; $display("FAIL right_end_req: got %0b expected 0", map.tile_req); end
  endtask
  task automatic test_blocked;
    exp_t e;
    do_reset;
    keycode = 16'h001a;
    tick;
    tests++;
    if (map.tile_req !== 1'b1 || map.tile_req_x !== 10'd2 || map.tile_req_y !== 10'd1 || Dir !== 2'd0) begin
      fails++;
      $display("FAIL blocked_req: got req=%0b (%0d,%0d) dir=%0d expected req=1 (2,1) dir=0",
               map.tile_req, map.tile_req_x, map.tile_req_y, Dir);
    end
    map.tile_ack = 1'b1;
    map.tile_blocked = 1'b1;
    push(32, 32, 0, 1'b0);
    tick;
    map.tile_ack = 1'b0;
    map.tile_blocked = 1'b0;
    keycode = '0;
    e = sb.pop_front();
    tests++;
    if (PosX !== e.x || PosY !== e.y || Dir !== e.d || Moving !== e.m || map.tile_req !== 1'b0) begin
      fails++;
      $display("FAIL blocked_ack: got x=%0d y=%0d dir=%0d mv=%0b req=%0b expected x=%0d y=%0d dir=%0d mv=%0b req=0",
               PosX, PosY, Dir, Moving, map.tile_req, e.x, e.y, e.d, e.m);
    end
    tick;
    tests++;
    if (Moving !== 1'b0 || map.tile_req !== 1'b0 || PosY !== 10'd32) begin
      fails++;
      $display("FAIL blocked_idle: got mv=%0b req=%0b y=%0d expected mv=0 req=0 y=32", Moving, map.tile_req, PosY);
    end
  endtask
  task automatic test_boundary;
    do_reset;
    go(16'h0004);
    go(16'h0004);
    go(16'h0016);
    tests++;
    if (PosX !== 10'd0 || PosY !== 10'd48 || Dir !== 2'd2) begin
      fails++;
      $display("FAIL edge_setup: got (%0d,%0d) dir=%0d expected (0,48) dir=2", PosX, PosY, Dir);
    end
    keycode = 16'h0004;
    for (int i = 0; i < 4; i++) begin
      tick;
      tests++;
      if (map.tile_req !== 1'b0) begin fails++; $display("FAIL edge_req%0d: got %0b expected 0", i, map.tile_req); end
    end
    tests++;
    if (Dir !== 2'd1 || PosX !== 10'd0 || Moving !== 1'b0) begin
      fails++;
      $display("FAIL edge_state: got dir=%0d x=%0d mv=%0b expected dir=1 x=0 mv=0", Dir, PosX, Moving);
    end
    keycode = '0;
  endtask
  task automatic test_priority_delay;
    exp_t e;
    do_reset;
    keycode = 16'h1a07;
    tick;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) keycode = 16'h0016;
      tests++;
      if (map.tile_req !== 1'b1 || map.tile_req_x !== 10'd3 || map.tile_req_y !== 10'd2 || PosX !== 10'd32 || Moving !== 1'b0) begin
        fails++;
        $display("FAIL hold_req%0d: got req=%0b (%0d,%0d) x=%0d mv=%0b expected req=1 (3,2) x=32 mv=0",
                 i, map.tile_req, map.tile_req_x, map.tile_req_y, PosX, Moving);
      end
      tick;
    end
    map.tile_ack = 1'b1;
    keycode = '0;
    push(32, 32, 3, 1'b1);
    for (int i = 1; i <= 8; i++) push(32 + 2 * i, 32, 3, i != 8);
    for (int i = 0; i < 9; i++) begin
      tick;
      map.tile_ack = 1'b0;
      e = sb.pop_front();
      tests++;
      if (PosX !== e.x || PosY !== e.y || Dir !== e.d || Moving !== e.m) begin
        fails++;
        $display("FAIL prio_step%0d: got x=%0d y=%0d dir=%0d mv=%0b expected x=%0d y=%0d dir=%0d mv=%0b",
                 i, PosX, PosY, Dir, Moving, e.x, e.y, e.d, e.m);
      end
    end
  endtask
  task automatic test_back_to_back;
    exp_t e;
    do_reset;
    keycode = 16'h0007;
    tick;
    for (int k = 1; k <= 18; k++) push(k <= 9 ? 32 + 2 * (k - 1) : 48 + 2 * (k - 10), 32, 3, k != 9 && k != 18);
    for (int k = 1; k <= 18; k++) begin
      map.tile_ack = map.tile_req;
      tick;
      e = sb.pop_front();
      tests++;
      if (PosX !== e.x || PosY !== e.y || Dir !== e.d || Moving !== e.m) begin
        fails++;
        $display("FAIL b2b_edge%0d: got x=%0d y=%0d dir=%0d mv=%0b expected x=%0d y=%0d dir=%0d mv=%0b",
                 k, PosX, PosY, Dir, Moving, e.x, e.y, e.d, e.m);
      end
    end
    keycode = '0;
    map.tile_ack = 1'b0;
  endtask
  task automatic test_reset_abort;
    do_reset;
    keycode = 16'h0007;
    tick;
    for (int k = 1; k <= 13; k++) begin
      map.tile_ack = map.tile_req;
      tick;
    end
    tests++;
    if (PosX !== 10'd54 || Moving !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: got x=%0d mv=%0b expected x=54 mv=1", PosX, Moving);
    end
    Reset = 1'b1;
    map.tile_ack = 1'b1;
    tick;
    Reset = 1'b0;
    keycode = '0;
    tests++;
    if (PosX !== 10'd32 || Moving !== 1'b0 || map.tile_req !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset: got x=%0d mv=%0b req=%0b expected x=32 mv=0 req=0", PosX, Moving, map.tile_req);
    end
    tick;
    tests++;
    if (PosX !== 10'd32 || Moving !== 1'b0 || map.tile_req !== 1'b0) begin
      fails++;
      $display("FAIL abort_late_ack: got x=%0d mv=%0b req=%0b expected x=32 mv=0 req=0", PosX, Moving, map.tile_req);
    end
    map.tile_ack = 1'b0;
  endtask
  task automatic test_reverse;
    exp_t e;
    int n;
    do_reset;
    keycode = 16'h0007;
    tick;
    map.tile_ack = 1'b1;
    tick;
    map.tile_ack = 1'b0;
    keycode = '0;
    repeat (3) tick;
    tests++;
    if (PosX !== 10'd38) begin fails++; $display("FAIL rev_setup: got x=%0d expected 38", PosX); end
    keycode = 16'h0004;
`ifdef GRID_MOVER_REVERSE_EN
    n = 3;
    push(36, 32, 1, 1'b1);
    push(34, 32, 1, 1'b1);
    push(32, 32, 1, 1'b0);
`else
    n = 5;
    for (int i = 1; i <= 5; i++) push(38 + 2 * i, 32, 3, i != 5);
`endif
    for (int i = 0; i < n; i++) begin
      tick;
      if (i == 0) begin
        keycode = '0;
        tests++;
        if (map.tile_req !== 1'b0) begin fails++; $display("FAIL rev_req: got %0b expected 0", map.tile_req); end
      end
      e = sb.pop_front();
      tests++;
      if (PosX !== e.x || PosY !== e.y || Dir !== e.d || Moving !== e.m) begin
        fails++;
        $display("FAIL rev_step%0d: got x=%0d y=%0d dir=%0d mv=%0b expected x=%0d y=%0d dir=%0d mv=%0b",
                 i, PosX, PosY, Dir, Moving, e.x, e.y, e.d, e.m);
      end
    end
  endtask
  initial begin
    Reset = 1'b1;
    keycode = '0;
    map.tile_ack = 1'b0;
    map.tile_blocked = 1'b0;
    test_reset;
    test_move_right;
    test_blocked;
    test_boundary;
    test_priority_delay;
    test_back_to_back;
    test_reset_abort;
    test_reverse;
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
